softmax_outp_writeback: RTL and testbench
=========================================

SOFTMAX_OUTP_WRITEBACK -- requirements
Module: softmax_outp_writeback

Interface
REQ-001 SHALL use compile-time macros: `DATAWIDTH, default 16, lane width; `NUM, default 4, lanes per word; `ADDRSIZE, default 8, address width.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 init  input  1  latch base_addr/end_addr and arm the block.
REQ-006 base_addr  input  `ADDRSIZE  first result-memory address.
REQ-007 end_addr  input  `ADDRSIZE  last result-memory address, inclusive.
REQ-008 in_valid  input  1  softmax final-stage result valid; this input cannot be stalled.
REQ-009 in_data  input  `DATAWIDTH*`NUM  packed softmax result lanes.
REQ-010 wr_ready  input  1  result memory accepts a write this cycle.
REQ-011 wr_en  output  1  write request.
REQ-012 wr_addr  output  `ADDRSIZE  write address.
REQ-013 wr_data  output  `DATAWIDTH*`NUM  write data.
REQ-014 busy  output  1  high in ARMED or RUN.
REQ-015 complete  output  1  one-cycle pulse after the last write is accepted.
REQ-016 overflow  output  1  sticky; set when a word is dropped.

Function
REQ-017 SHALL implement FSM states IDLE, ARMED, RUN.
- IDLE -> ARMED on init.
- ARMED -> RUN on the first accepted push.
- RUN -> IDLE when a write at wr_addr==end_addr is accepted.
REQ-018 SHALL contain a 4-entry FIFO of `DATAWIDTH*`NUM words with registered storage, plus full and empty flags.
REQ-019 SHALL push in_data when in_valid, state!=IDLE, FIFO not full, and pushes accepted since init < end_addr-base_addr+1.
REQ-020 SHALL drop the word and set overflow when in_valid is high, state!=IDLE, and either the FIFO is full or the push quota is exhausted.
REQ-021 SHALL drive wr_en = (state==RUN) & ~empty; wr_data = FIFO head; wr_addr = write pointer.
REQ-022 On a write handshake (wr_en & wr_ready), SHALL pop the FIFO and increment the write pointer; wr_addr, wr_data and wr_en SHALL hold while wr_ready is low.
REQ-023 Latency: with the FIFO empty and wr_ready high, in_valid at cycle t SHALL give wr_en=1 at cycle t+1.
REQ-024 Push and pop in the same cycle on a full FIFO SHALL both succeed, with occupancy unchanged and no overflow.
REQ-025 The write pointer SHALL be `ADDRSIZE wide; base_addr > end_addr is unsupported, and wrap at 2^`ADDRSIZE-1 -> 0 SHALL be modular.
REQ-026 init in any state SHALL:
- relatch base_addr/end_addr;
- flush the FIFO;
- clear overflow and the push count;
- enter ARMED, with no complete pulse.
REQ-027 complete SHALL pulse the cycle after the final write handshake; busy SHALL be low in that same cycle.
REQ-028 in_valid while IDLE SHALL be ignored, without setting overflow.

Reset
REQ-029 On reset, SHALL drive: state IDLE; FIFO empty; write pointer 0; push count 0; wr_en 0; wr_addr 0; wr_data 0; busy 0; complete 0; overflow 0.
REQ-030 Reset SHALL take priority over init and all other inputs in the same cycle.
REQ-031 Reset mid-RUN SHALL abort with no further writes and no complete pulse.

Configuration
REQ-032 Macro SOFTMAX_WB_STATUS_EN:
- When defined, SHALL add output port words_written [`ADDRSIZE:0], reset to 0 and on init, incremented per write handshake.
- When undefined, the port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-033 base=0x10, end=0x13, 4 consecutive in_valid words A..D, wr_ready=1 -> writes A..D at 0x10..0x13 starting 1 cycle after the first in_valid; complete pulses once; overflow=0.
REQ-034 base=0, end=7, 8 consecutive in_valid, wr_ready low for the first 6 cycles -> words 0..3 buffered, words 4..5 dropped; overflow=1; remaining writes are in order with no gaps in address.
REQ-035 base=0, end=1, 3 in_valid -> 2 writes; third word dropped; overflow=1; complete pulses once.
REQ-036 FIFO full with wr_ready=1 and in_valid=1 for 10 cycles -> no overflow; occupancy stays at 4.
REQ-037 Reset asserted after 2 of 4 writes -> all outputs 0 the next cycle; no complete; a later init plus 4 words completes normally.
REQ-038 With SOFTMAX_WB_STATUS_EN defined, repeat REQ-033 -> words_written = 4 after complete; init returns it to 0.

Source files
------------

// File: rtl/softmax_outp_writeback.sv
// softmax_outp_writeback
//
// Collects the packed lanes produced by the final softmax stage and writes them
// to consecutive result-memory addresses, from base_addr up to end_addr
// inclusive. The softmax pipeline cannot be stalled. A 4-entry FIFO absorbs
// write back-pressure. If a word arrives while the FIFO is full, or after the
// expected number of words has already been accepted, the word is dropped and
// the sticky overflow flag is set.
//
// Compile-time macros:
//   DATAWIDTH            lane width (default 16)
//   NUM                  lanes per word (default 4)
//   ADDRSIZE             address width (default 8)
//   SOFTMAX_WB_STATUS_EN optional; adds the words_written status counter port
//
// Ports:
//   clk           clock; all state updates on its rising edge
//   reset         synchronous active-high reset
//   init          latch base_addr/end_addr, flush the FIFO and arm the block
//   base_addr     first result-memory address
//   end_addr      last result-memory address, inclusive
//   in_valid      softmax result valid (cannot be stalled)
//   in_data       packed softmax result lanes
//   wr_ready      result memory accepts a write this cycle
//   wr_en         write request
//   wr_addr       write address
//   wr_data       write data
//   busy          high while ARMED or RUN
//   complete      one-cycle pulse after the last write is accepted
//   overflow      sticky; set when a word is dropped
//   words_written (SOFTMAX_WB_STATUS_EN only) write handshakes since init

`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef NUM
`define NUM 4
`endif
`ifndef ADDRSIZE
`define ADDRSIZE 8
`endif

module softmax_outp_writeback (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init,
    input  logic [`ADDRSIZE-1:0]           base_addr,
    input  logic [`ADDRSIZE-1:0]           end_addr,
    input  logic                           in_valid,
    input  logic [`DATAWIDTH*`NUM-1:0]     in_data,
    input  logic                           wr_ready,
    output logic                           wr_en,
    output logic [`ADDRSIZE-1:0]           wr_addr,
    output logic [`DATAWIDTH*`NUM-1:0]     wr_data,
    output logic                           busy,
    output logic                           complete,
    output logic                           overflow
`ifdef SOFTMAX_WB_STATUS_EN
    ,
    output logic [`ADDRSIZE:0]             words_written
`endif
);

    localparam int W     = `DATAWIDTH * `NUM;
    localparam int A     = `ADDRSIZE;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    // FIFO storage and bookkeeping
    logic [W-1:0]   mem [0:DEPTH-1];
    logic [1:0]     rd_ptr;
    logic [1:0]     fifo_wr_ptr;
    logic [2:0]     count;
    logic           full;
    logic           empty;

    // Address tracking and push quota. The quota can reach 2^A, so it and the
    // push counter are one bit wider than an address.
    logic [A-1:0]   wr_ptr;
    logic [A-1:0]   end_q;
    logic [A:0]     quota;
    logic [A:0]     push_cnt;

    logic           active;
    logic           quota_left;
    logic           room;
    logic           push;
    logic           pop;
    logic           drop;
    logic           last_write;

    assign full       = (count == 3'(DEPTH));
    assign empty      = (count == 3'd0);
    assign active     = (state != IDLE);
    assign busy       = active;

    assign wr_en      = (state == RUN) && !empty;
    assign wr_addr    = wr_ptr;
    assign wr_data    = mem[rd_ptr];

    assign pop        = wr_en && wr_ready;
    assign last_write = pop && (wr_ptr == end_q);

    // A slot that is freed by a pop in the same cycle can take the incoming
    // word. This lets a full FIFO keep streaming without dropping words.
    assign room       = !full || pop;
    assign quota_left = (push_cnt < quota);
    assign push       = in_valid && active && room && quota_left;
    assign drop       = in_valid && active && !(room && quota_left);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: assign a default first so no path leaves state_nxt
        // unassigned, which would infer a latch.
        state_nxt = state;
        if (init) begin
            state_nxt = ARMED;
        end else begin
            unique case (state)
                IDLE:    state_nxt = IDLE;
                ARMED:   if (push)       state_nxt = RUN;
                RUN:     if (last_write) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO, address and status datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the FIFO storage is only four words, so it is reset.
            // This makes wr_data (the FIFO head) read as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr      <= '0;
            fifo_wr_ptr <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            end_q       <= '0;
            quota       <= '0;
            push_cnt    <= '0;
            overflow    <= 1'b0;
            complete    <= 1'b0;
        end else if (init) begin
            // Flush: the old storage contents become unreachable because
            // both pointers and the count restart.
            rd_ptr      <= '0;
            fifo_wr_ptr <= '0;
            count       <= '0;
            wr_ptr      <= base_addr;
            end_q       <= end_addr;
            quota       <= {1'b0, end_addr} - {1'b0, base_addr} + (A+1)'(1);
            push_cnt    <= '0;
            overflow    <= 1'b0;
            complete    <= 1'b0;
        end else begin
            if (push) begin
                mem[fifo_wr_ptr] <= in_data;
                fifo_wr_ptr      <= fifo_wr_ptr + 2'd1;
                push_cnt         <= push_cnt + (A+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
                wr_ptr <= wr_ptr + A'(1);   // wraps modulo 2^A
            end
            unique case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
            complete <= last_write;
        end
    end

`ifdef SOFTMAX_WB_STATUS_EN
    always_ff @(posedge clk) begin
        if (reset || init) begin
            words_written <= '0;
        end else if (pop) begin
            words_written <= words_written + (A+1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_softmax_outp_writeback.sv
// Self-checking bench for softmax_outp_writeback, using directed vectors.
// Expected write sequences are written out by hand for each scenario. A
// negedge monitor records every write handshake and every complete pulse.

`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif
`ifndef NUM
`define NUM 4
`endif
`ifndef ADDRSIZE
`define ADDRSIZE 8
`endif

module tb_softmax_outp_writeback;

    localparam int W = `DATAWIDTH * `NUM;
    localparam int A = `ADDRSIZE;

    logic           clk = 1'b0;
    logic           reset;
    logic           init;
    logic [A-1:0]   base_addr;
    logic [A-1:0]   end_addr;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           wr_ready;
    logic           wr_en;
    logic [A-1:0]   wr_addr;
    logic [W-1:0]   wr_data;
    logic           busy;
    logic           complete;
    logic           overflow;
`ifdef SOFTMAX_WB_STATUS_EN
    logic [A:0]     words_written;
`endif

    softmax_outp_writeback dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .base_addr (base_addr),
        .end_addr  (end_addr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .wr_ready  (wr_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .complete  (complete),
        .overflow  (overflow)
`ifdef SOFTMAX_WB_STATUS_EN
        ,
        .words_written (words_written)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, written only by the monitor process
    logic [A-1:0] q_addr[$];
    logic [W-1:0] q_data[$];
    int           cpl_cnt = 0;

    // Expected writes for the current scenario, written only by the stimulus
    logic [A-1:0] exp_addr[$];
    logic [W-1:0] exp_data[$];

    always @(negedge clk) begin
        if (wr_en && wr_ready) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
        if (complete) cpl_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] word(input int k);
        logic [`DATAWIDTH-1:0] lane;
        lane = k[`DATAWIDTH-1:0];
        return {`NUM{lane}};
    endfunction

    // Advance one cycle; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [A-1:0] b, input logic [A-1:0] e);
        init      = 1'b1;
        base_addr = b;
        end_addr  = e;
        step();
        init      = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int start);
        check({tag, "_nwr"}, 128'(q_addr.size() - start), 128'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (start + i < q_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 128'(q_addr[start+i]), 128'(exp_addr[i]));
                check($sformatf("%s_data%0d", tag, i), 128'(q_data[start+i]), 128'(exp_data[i]));
            end
        end
    endtask

    initial begin
        int qs;
        int cs;
        int bad;

        reset = 1'b1; init = 1'b0; base_addr = '0; end_addr = '0;
        in_valid = 1'b0; in_data = '0; wr_ready = 1'b0;
        step();
        // Reset has priority over init
        init = 1'b1; base_addr = 8'h55; end_addr = 8'h66;
        step();
        init = 1'b0;
        check("rst_wr_en",    128'(wr_en),    128'(0));
        check("rst_wr_addr",  128'(wr_addr),  128'(0));
        check("rst_wr_data",  128'(wr_data),  128'(0));
        check("rst_busy",     128'(busy),     128'(0));
        check("rst_complete", 128'(complete), 128'(0));
        check("rst_overflow", 128'(overflow), 128'(0));
        reset = 1'b0;
        step();

        // ---- Scenario 1: four words, no back-pressure ----
        qs = q_addr.size(); cs = cpl_cnt;
        do_init(8'h10, 8'h13);
        check("s1_busy_armed", 128'(busy), 128'(1));
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = word(16'hA1 + i);
            if (i == 0) check("s1_lat_t0", 128'(wr_en), 128'(0));
            step();
            if (i == 0) begin
                check("s1_lat_t1", 128'(wr_en), 128'(1));
                check("s1_t1_addr", 128'(wr_addr), 128'(8'h10));
                check("s1_t1_data", 128'(wr_data), 128'(word(16'hA1)));
            end
        end
        in_valid = 1'b0;
        step();
        check("s1_complete", 128'(complete), 128'(1));
        check("s1_busy_done", 128'(busy), 128'(0));
        check("s1_wr_en_done", 128'(wr_en), 128'(0));
        step();
        check("s1_complete_pulse", 128'(complete), 128'(0));
        exp_addr = {8'h10, 8'h11, 8'h12, 8'h13};
        exp_data = {word(16'hA1), word(16'hA2), word(16'hA3), word(16'hA4)};
        check_writes("s1", qs);
        check("s1_cpl_cnt", 128'(cpl_cnt - cs), 128'(1));
        check("s1_overflow", 128'(overflow), 128'(0));
`ifdef SOFTMAX_WB_STATUS_EN
        check("s1_words_written", 128'(words_written), 128'(4));
`endif
        // In IDLE, in_valid is ignored
        qs = q_addr.size();
        in_valid = 1'b1; in_data = word(16'hEE);
        step(); step();
        in_valid = 1'b0;
        check("idle_overflow", 128'(overflow), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_nwr", 128'(q_addr.size() - qs), 128'(0));

        // ---- Scenario 2: back-pressure causes drops ----
        qs = q_addr.size(); cs = cpl_cnt;
        wr_ready = 1'b0;
        do_init(8'h00, 8'h07);
`ifdef SOFTMAX_WB_STATUS_EN
        check("s2_words_written_init", 128'(words_written), 128'(0));
`endif
        for (int i = 0; i < 8; i++) begin
            wr_ready = (i >= 6);
            in_valid = 1'b1; in_data = word(16'hB0 + i);
            step();
            if (i == 3) begin
                check("s2_hold_en",   128'(wr_en),   128'(1));
                check("s2_hold_addr", 128'(wr_addr), 128'(0));
                check("s2_hold_data", 128'(wr_data), 128'(word(16'hB0)));
            end
        end
        in_valid = 1'b0; wr_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        exp_addr = {8'h0, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5};
        exp_data = {word(16'hB0), word(16'hB1), word(16'hB2), word(16'hB3),
                    word(16'hB6), word(16'hB7)};
        check_writes("s2", qs);
        check("s2_overflow", 128'(overflow), 128'(1));
        check("s2_no_complete", 128'(cpl_cnt - cs), 128'(0));
        check("s2_still_busy", 128'(busy), 128'(1));

        // init in RUN re-arms the block and clears overflow
        qs = q_addr.size(); cs = cpl_cnt;
        do_init(8'h40, 8'h40);
        check("reinit_overflow", 128'(overflow), 128'(0));
        check("reinit_busy", 128'(busy), 128'(1));
        check("reinit_wr_en", 128'(wr_en), 128'(0));
        in_valid = 1'b1; in_data = word(16'h77);
        step();
        in_valid = 1'b0;
        step(); step();
        exp_addr = {8'h40};
        exp_data = {word(16'h77)};
        check_writes("reinit", qs);
        check("reinit_cpl", 128'(cpl_cnt - cs), 128'(1));

        // ---- Scenario 3: quota exhausted ----
        qs = q_addr.size(); cs = cpl_cnt;
        do_init(8'h00, 8'h01);
        wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = word(16'hC0 + i);
            step();
        end
        in_valid = 1'b0;
        check("s3_complete", 128'(complete), 128'(1));
        step(); step();
        exp_addr = {8'h0, 8'h1};
        exp_data = {word(16'hC0), word(16'hC1)};
        check_writes("s3", qs);
        check("s3_overflow", 128'(overflow), 128'(1));
        check("s3_cpl_cnt", 128'(cpl_cnt - cs), 128'(1));

        // ---- Scenario 4: full FIFO streams with push and pop together ----
        qs = q_addr.size();
        wr_ready = 1'b0;
        do_init(8'h00, 8'h3F);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = word(16'h40 + i);
            step();
        end
        bad = 0;
        wr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = word(16'h44 + i);
            if (!wr_en) bad++;
            step();
        end
        in_valid = 1'b0;
        check("s4_wr_en_streaming", 128'(bad), 128'(0));
        check("s4_overflow", 128'(overflow), 128'(0));
        check("s4_nwr_before_drain", 128'(q_addr.size() - qs), 128'(10));
        for (int i = 0; i < 4; i++) step();
        check("s4_drained", 128'(wr_en), 128'(0));
        exp_addr.delete(); exp_data.delete();
        for (int i = 0; i < 14; i++) begin
            exp_addr.push_back(A'(i));
            exp_data.push_back(word(16'h40 + i));
        end
        check_writes("s4", qs);

        // ---- Scenario 5: reset mid-run, then a clean run ----
        qs = q_addr.size(); cs = cpl_cnt;
        do_init(8'h20, 8'h23);
        wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = word(16'hD0 + i);
            step();
        end
        reset = 1'b1; in_valid = 1'b0; wr_ready = 1'b0;
        step();
        reset = 1'b0;
        check("s5_wr_en",    128'(wr_en),    128'(0));
        check("s5_wr_addr",  128'(wr_addr),  128'(0));
        check("s5_wr_data",  128'(wr_data),  128'(0));
        check("s5_busy",     128'(busy),     128'(0));
        check("s5_complete", 128'(complete), 128'(0));
        check("s5_overflow", 128'(overflow), 128'(0));
        wr_ready = 1'b1;
        step(); step(); step();
        exp_addr = {8'h20, 8'h21};
        exp_data = {word(16'hD0), word(16'hD1)};
        check_writes("s5_abort", qs);
        check("s5_abort_cpl", 128'(cpl_cnt - cs), 128'(0));
        qs = q_addr.size();
        do_init(8'h30, 8'h33);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = word(16'hE0 + i);
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        exp_addr = {8'h30, 8'h31, 8'h32, 8'h33};
        exp_data = {word(16'hE0), word(16'hE1), word(16'hE2), word(16'hE3)};
        check_writes("s5_rerun", qs);
        check("s5_rerun_cpl", 128'(cpl_cnt - cs), 128'(1));
        check("s5_rerun_overflow", 128'(overflow), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
